// File: rtl/julia_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : julia_pixel_scheduler
// Purpose  : Raster-order pixel sequencer that seeds the Julia iteration core
//            and streams each pixel's iteration count downstream.
// Revision : 1.0
// ============================================================================
module julia_pixel_scheduler #(
  parameter  int INTEGER_BITS    = 8,
  parameter  int FRACTIONAL_BITS = 24,
  parameter  int MAX_ITER_WIDTH  = 16,
  parameter  int X_WIDTH         = 11,
  parameter  int Y_WIDTH         = 10,
  localparam int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      frame_start_i,
  input  logic [X_WIDTH-1:0]        width_i,
  input  logic [Y_WIDTH-1:0]        height_i,
  input  logic [DATA_WIDTH-1:0]     x_min_i,
  input  logic [DATA_WIDTH-1:0]     y_max_i,
  input  logic [DATA_WIDTH-1:0]     step_i,
  input  logic [DATA_WIDTH-1:0]     cx_i,
  input  logic [DATA_WIDTH-1:0]     cy_i,
  input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
  output logic                      core_start_o,
  output logic [DATA_WIDTH-1:0]     core_zx_o,
  output logic [DATA_WIDTH-1:0]     core_zy_o,
  output logic [DATA_WIDTH-1:0]     core_cx_o,
  output logic [DATA_WIDTH-1:0]     core_cy_o,
  output logic [MAX_ITER_WIDTH-1:0] core_max_iter_o,
  input  logic [MAX_ITER_WIDTH-1:0] core_iter_i,
  input  logic                      core_done_i,
  output logic                      pix_valid_o,
  input  logic                      pix_ready_i,
  output logic [MAX_ITER_WIDTH-1:0] pix_iter_o,
  output logic [X_WIDTH-1:0]        pix_x_o,
  output logic [Y_WIDTH-1:0]        pix_y_o,
  output logic                      pix_eol_o,
  output logic                      pix_last_o,
  output logic                      busy_o,
  output logic                      frame_done_o
);

  localparam logic [X_WIDTH-1:0] c_x_one = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0] c_y_one = Y_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [X_WIDTH-1:0]        r_width;
  logic [Y_WIDTH-1:0]        r_height;
  logic [DATA_WIDTH-1:0]     r_x_min;
  logic [DATA_WIDTH-1:0]     r_step;
  logic [DATA_WIDTH-1:0]     r_cx;
  logic [DATA_WIDTH-1:0]     r_cy;
  logic [MAX_ITER_WIDTH-1:0] r_max_iter;
  logic [X_WIDTH-1:0]        r_col;
  logic [Y_WIDTH-1:0]        r_row;
  logic [DATA_WIDTH-1:0]     r_zx_acc;
  logic [DATA_WIDTH-1:0]     r_zy_acc;

  logic                      r_pix_valid;
  logic [MAX_ITER_WIDTH-1:0] r_pix_iter;
  logic [X_WIDTH-1:0]        r_pix_x;
  logic [Y_WIDTH-1:0]        r_pix_y;
  logic                      r_pix_eol;
  logic                      r_pix_last;
  logic                      r_busy;
  logic                      r_frame_done;

  logic w_empty_frame;
  logic w_slot_free;
  logic w_eol;
  logic w_last;
  logic w_load_frame;
  logic w_capture;
  logic w_frame_end;

  assign w_empty_frame = (width_i == '0) || (height_i == '0);
  assign w_slot_free   = !r_pix_valid || pix_ready_i;
  assign w_eol         = (r_col == (r_width - c_x_one));
  assign w_last        = w_eol && (r_row == (r_height - c_y_one));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_frame = 1'b0;
    w_capture    = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start_i) begin
          w_load_frame = 1'b1;
          if (!w_empty_frame) begin
            w_state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // done is trustworthy here: the core drops it on the edge that saw start
        if (core_done_i) begin
          if (w_slot_free) begin
            w_capture = 1'b1;
          end else begin
            w_state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_slot_free) begin
          w_capture = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_pix_valid && pix_ready_i) begin
          w_frame_end  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (w_capture) begin
      w_state_next = w_last ? S_DRAIN : S_ISSUE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_width      <= '0;
      r_height     <= '0;
      r_x_min      <= '0;
      r_step       <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_max_iter   <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_zx_acc     <= '0;
      r_zy_acc     <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_iter   <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_eol    <= 1'b0;
      r_pix_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      // An empty frame raises busy for one cycle alongside its done pulse
      if (r_state == S_IDLE && !w_load_frame) begin
        r_busy <= 1'b0;
      end
      if (w_load_frame) begin
        r_width      <= width_i;
        r_height     <= height_i;
        r_x_min      <= x_min_i;
        r_step       <= step_i;
        r_cx         <= cx_i;
        r_cy         <= cy_i;
        r_max_iter   <= max_iter_i;
        r_col        <= '0;
        r_row        <= '0;
        r_zx_acc     <= x_min_i;
        r_zy_acc     <= y_max_i;
        r_busy       <= 1'b1;
        r_frame_done <= w_empty_frame;
      end
      if (w_capture) begin
        r_pix_valid <= 1'b1;
        r_pix_iter  <= core_iter_i;
        r_pix_x     <= r_col;
        r_pix_y     <= r_row;
        r_pix_eol   <= w_eol;
        r_pix_last  <= w_last;
        if (w_eol) begin
          r_col    <= '0;
          r_zx_acc <= r_x_min;
          r_row    <= r_row + c_y_one;
          r_zy_acc <= r_zy_acc - r_step;
        end else begin
          r_col    <= r_col + c_x_one;
          r_zx_acc <= r_zx_acc + r_step;
        end
      end else if (pix_ready_i) begin
        r_pix_valid <= 1'b0;
      end
      if (w_frame_end) begin
        r_frame_done <= 1'b1;
        r_busy       <= 1'b0;
      end
    end
  end

  // The accumulators only move on capture, so they double as the core's z inputs
  assign core_start_o    = (r_state == S_ISSUE);
  assign core_zx_o       = r_zx_acc;
  assign core_zy_o       = r_zy_acc;
  assign core_cx_o       = r_cx;
  assign core_cy_o       = r_cy;
  assign core_max_iter_o = r_max_iter;
  assign pix_valid_o     = r_pix_valid;
  assign pix_iter_o      = r_pix_iter;
  assign pix_x_o         = r_pix_x;
  assign pix_y_o         = r_pix_y;
  assign pix_eol_o       = r_pix_eol;
  assign pix_last_o      = r_pix_last;
  assign busy_o          = r_busy;
  assign frame_done_o    = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_julia_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_julia_pixel_scheduler
// Purpose  : Self-checking bench with a behavioural Julia core stub and a
//            raster-order pixel reference model.
// Revision : 1.0
// ============================================================================
module tb_julia_pixel_scheduler;
  localparam int DW = 32;
  localparam int MW = 16;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam real SCALE = 16777216.0;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          frame_start_i;
  logic [XW-1:0] width_i;
  logic [YW-1:0] height_i;
  logic [DW-1:0] x_min_i, y_max_i, step_i, cx_i, cy_i;
  logic [MW-1:0] max_iter_i;
  logic          core_start_o;
  logic [DW-1:0] core_zx_o, core_zy_o, core_cx_o, core_cy_o;
  logic [MW-1:0] core_max_iter_o;
  logic [MW-1:0] core_iter_i;
  logic          core_done_i;
  logic          pix_valid_o, pix_ready_i;
  logic [MW-1:0] pix_iter_o;
  logic [XW-1:0] pix_x_o;
  logic [YW-1:0] pix_y_o;
  logic          pix_eol_o, pix_last_o, busy_o, frame_done_o;

  always #5 clk_i = ~clk_i;

  julia_pixel_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .frame_start_i(frame_start_i),
    .width_i(width_i), .height_i(height_i), .x_min_i(x_min_i), .y_max_i(y_max_i),
    .step_i(step_i), .cx_i(cx_i), .cy_i(cy_i), .max_iter_i(max_iter_i),
    .core_start_o(core_start_o), .core_zx_o(core_zx_o), .core_zy_o(core_zy_o),
    .core_cx_o(core_cx_o), .core_cy_o(core_cy_o), .core_max_iter_o(core_max_iter_o),
    .core_iter_i(core_iter_i), .core_done_i(core_done_i),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .pix_iter_o(pix_iter_o),
    .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .pix_eol_o(pix_eol_o), .pix_last_o(pix_last_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int x; int y; int iter; bit eol; bit last; } pix_t;
  pix_t          exp_q[$];
  pix_t          obs_q[$];
  logic [2*DW-1:0] exp_z_q[$];
  logic [DW-1:0] exp_cx, exp_cy;
  logic [MW-1:0] exp_maxi;

  int n_starts = 0, n_done = 0, n_xfer = 0, n_valid_cycles = 0, stall_viol = 0;
  int out_base = 0, cur_out = 0;
  bit busy_at_done;
  bit prev_stall = 1'b0;
  logic [MW+XW+YW+1:0] prev_pix;

  // Escape-time count: iterations of z = z^2 + c before |z|^2 exceeds 4
  function automatic int julia(input logic [DW-1:0] zx, zy, cx, cy, input int maxi);
    real x, y, cr, ci, t;
    int  n;
    x  = $itor($signed(zx)) / SCALE;
    y  = $itor($signed(zy)) / SCALE;
    cr = $itor($signed(cx)) / SCALE;
    ci = $itor($signed(cy)) / SCALE;
    n  = 0;
    while (n < maxi && (x * x + y * y) <= 4.0) begin
      t = x * x - y * y + cr;
      y = 2.0 * x * y + ci;
      x = t;
      n++;
    end
    return n;
  endfunction

  // Core stub: random latency, done held until the next start
  int            core_cnt;
  logic [DW-1:0] lat_zx, lat_zy;
  always @(posedge clk_i) begin
    if (rst_i) begin
      core_done_i <= 1'b0;
      core_iter_i <= '0;
      core_cnt    <= 0;
    end else if (core_start_o) begin
      core_done_i <= 1'b0;
      lat_zx      <= core_zx_o;
      lat_zy      <= core_zy_o;
      core_cnt    <= int'($urandom_range(1, 6));
    end else if (core_cnt == 1) begin
      core_cnt    <= 0;
      core_done_i <= 1'b1;
      core_iter_i <= MW'(julia(lat_zx, lat_zy, core_cx_o, core_cy_o, int'(core_max_iter_o)));
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  // Scoreboard: core seeds and output transfers against the reference queues
  always @(negedge clk_i) begin
    pix_t p, e;
    logic [2*DW-1:0] ez;
    logic [MW+XW+YW+1:0] cur;
    if (rst_i) begin
      prev_stall = 1'b0;
      out_base   = n_starts - n_xfer;
    end else begin
      cur = {pix_iter_o, pix_x_o, pix_y_o, pix_eol_o, pix_last_o};
      if (prev_stall && cur !== prev_pix) stall_viol++;
      prev_stall = pix_valid_o && !pix_ready_i;
      prev_pix   = cur;
      if (pix_valid_o) n_valid_cycles++;
      if (frame_done_o) begin
        n_done++;
        busy_at_done = busy_o;
      end
      if (core_start_o) begin
        n_starts++;
        checks++;
        if (exp_z_q.size() == 0) begin
          errors++;
          $display("FAIL core_seed: unexpected start zx=%h zy=%h, required none", core_zx_o, core_zy_o);
        end else begin
          ez = exp_z_q.pop_front();
          if ({core_zx_o, core_zy_o, core_cx_o, core_cy_o, core_max_iter_o} !== {ez, exp_cx, exp_cy, exp_maxi}) begin
            errors++;
            $display("FAIL core_seed: got z=%h,%h c=%h,%h mi=%0d required z=%h,%h c=%h,%h mi=%0d",
                     core_zx_o, core_zy_o, core_cx_o, core_cy_o, core_max_iter_o,
                     ez[2*DW-1:DW], ez[DW-1:0], exp_cx, exp_cy, exp_maxi);
          end
        end
      end
      if (pix_valid_o && pix_ready_i) begin
        p.x = int'(pix_x_o); p.y = int'(pix_y_o); p.iter = int'(pix_iter_o);
        p.eol = pix_eol_o; p.last = pix_last_o;
        obs_q.push_back(p);
        n_xfer++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel: unexpected (%0d,%0d) iter=%0d, required none", p.x, p.y, p.iter);
        end else begin
          e = exp_q.pop_front();
          if (p.x !== e.x || p.y !== e.y || p.iter !== e.iter || p.eol !== e.eol || p.last !== e.last) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d) iter=%0d eol=%0b last=%0b required (%0d,%0d) iter=%0d eol=%0b last=%0b",
                     p.x, p.y, p.iter, p.eol, p.last, e.x, e.y, e.iter, e.eol, e.last);
          end
        end
      end
      cur_out = n_starts - n_xfer - out_base;
    end
  end

  task automatic build_expected(input int w, h, input logic [DW-1:0] xmin, ymax, step, cx, cy, input int maxi);
    pix_t p;
    logic [DW-1:0] zx, zy;
    exp_q.delete(); exp_z_q.delete(); obs_q.delete();
    exp_cx = cx; exp_cy = cy; exp_maxi = MW'(maxi);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        zx = xmin + DW'(c) * step;
        zy = ymax - DW'(r) * step;
        p.x = c; p.y = r; p.iter = julia(zx, zy, cx, cy, maxi);
        p.eol = (c == w - 1); p.last = (c == w - 1) && (r == h - 1);
        exp_q.push_back(p);
        exp_z_q.push_back({zx, zy});
      end
    end
  endtask

  task automatic drive_cfg(input int w, h, input logic [DW-1:0] xmin, ymax, step, cx, cy, input int maxi);
    width_i = XW'(w); height_i = YW'(h); x_min_i = xmin; y_max_i = ymax;
    step_i = step; cx_i = cx; cy_i = cy; max_iter_i = MW'(maxi);
  endtask

  task automatic run_frame(input int w, h, input logic [DW-1:0] xmin, ymax, step, cx, cy, input int maxi,
                           input int rdy_pct, input bit do_stall, input bit do_restart,
                           output int starts, output int dones, output int viol, output int mx, output bit tmo);
    int s0, d0, v0, stall_left;
    bit stalled;
    build_expected(w, h, xmin, ymax, step, cx, cy, maxi);
    s0 = n_starts; d0 = n_done; v0 = stall_viol;
    mx = 0; stalled = 1'b0; stall_left = 0; tmo = 1'b1;
    drive_cfg(w, h, xmin, ymax, step, cx, cy, maxi);
    frame_start_i = 1'b1;
    pix_ready_i = 1'b1;
    @(posedge clk_i); #1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (do_stall && !stalled && pix_valid_o) begin
        stalled = 1'b1;
        stall_left = 20;
      end
      if (stall_left > 0) begin
        pix_ready_i = 1'b0;
        stall_left--;
      end else begin
        pix_ready_i = ($urandom_range(0, 99) < rdy_pct);
      end
      if (do_restart && cyc == 6) begin
        frame_start_i = 1'b1;
        drive_cfg(w + 3, h + 2, ~xmin, ~ymax, step + 1, cx + 5, cy + 7, 3);
      end else begin
        frame_start_i = 1'b0;
      end
      @(negedge clk_i);
      if (cur_out > mx) mx = cur_out;
      if (n_done != d0) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk_i); #1;
    end
    pix_ready_i = 1'b1;
    frame_start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    starts = n_starts - s0;
    dones  = n_done - d0;
    viol   = stall_viol - v0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; frame_start_i = 1'b0; pix_ready_i = 1'b1;
    drive_cfg(0, 0, '0, '0, '0, '0, '0, 0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({core_start_o, core_zx_o, core_zy_o, core_cx_o, core_cy_o, core_max_iter_o, pix_valid_o, pix_iter_o,
         pix_x_o, pix_y_o, pix_eol_o, pix_last_o, busy_o, frame_done_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%0b busy=%0b valid=%0b done=%0b zx=%h, required all zero",
               core_start_o, busy_o, pix_valid_o, frame_done_o, core_zx_o);
    end
  endtask

  task automatic test_2x1;
    int st, dn, vi, mx; bit tmo;
    run_frame(2, 1, 32'hFE00_0000, 32'h0100_0000, 32'h0100_0000, '0, '0, 10, 100, 1'b0, 1'b0, st, dn, vi, mx, tmo);
    checks++;
    if (tmo !== 1'b0 || dn !== 1) begin
      errors++; $display("FAIL 2x1_done: timeout=%0b done_pulses=%0d, required 0 and 1", tmo, dn);
    end
    checks++;
    if (obs_q.size() !== 2) begin
      errors++; $display("FAIL 2x1_count: got %0d pixels, required 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].iter !== 0 || obs_q[0].eol !== 1'b0 || obs_q[0].last !== 1'b0) begin
        errors++; $display("FAIL 2x1_pix0: got iter=%0d eol=%0b last=%0b, required 0 0 0", obs_q[0].iter, obs_q[0].eol, obs_q[0].last);
      end
      checks++;
      if (obs_q[1].iter !== 2 || obs_q[1].eol !== 1'b1 || obs_q[1].last !== 1'b1 || obs_q[1].x !== 1) begin
        errors++; $display("FAIL 2x1_pix1: got x=%0d iter=%0d eol=%0b last=%0b, required 1 2 1 1", obs_q[1].x, obs_q[1].iter, obs_q[1].eol, obs_q[1].last);
      end
    end
    checks++;
    if (busy_at_done !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL 2x1_busy: got busy_at_done=%0b busy=%0b, required 0", busy_at_done, busy_o);
    end
  endtask

  task automatic test_3x2;
    int st, dn, vi, mx; bit tmo;
    run_frame(3, 2, 32'hFF00_0000, 32'h0080_0000, 32'h0080_0000, '0, '0, 20, 100, 1'b0, 1'b0, st, dn, vi, mx, tmo);
    checks++;
    if (tmo !== 1'b0 || st !== 6 || dn !== 1 || exp_q.size() !== 0) begin
      errors++; $display("FAIL 3x2_frame: timeout=%0b starts=%0d dones=%0d missing=%0d, required 0 6 1 0", tmo, st, dn, exp_q.size());
    end
    checks++;
    if (obs_q.size() !== 6) begin
      errors++; $display("FAIL 3x2_count: got %0d pixels, required 6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs_q[i].eol !== (i % 3 == 2) || obs_q[i].last !== (i == 5)) begin
          errors++; $display("FAIL 3x2_flags: pixel %0d eol=%0b last=%0b, required %0b %0b", i, obs_q[i].eol, obs_q[i].last, (i % 3 == 2), (i == 5));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int st, dn, vi, mx; bit tmo;
    run_frame(3, 2, 32'hFF00_0000, 32'h0080_0000, 32'h0080_0000, '0, '0, 20, 100, 1'b1, 1'b0, st, dn, vi, mx, tmo);
    checks++;
    if (tmo !== 1'b0 || st !== 6 || dn !== 1 || exp_q.size() !== 0 || obs_q.size() !== 6) begin
      errors++; $display("FAIL bp_frame: timeout=%0b starts=%0d dones=%0d pixels=%0d, required 0 6 1 6", tmo, st, dn, obs_q.size());
    end
    checks++;
    if (vi !== 0) begin
      errors++; $display("FAIL bp_stable: got %0d unstable stalled cycles, required 0", vi);
    end
    checks++;
    if (mx !== 2) begin
      errors++; $display("FAIL bp_buffer: got %0d runs outstanding at most, required 2", mx);
    end
  endtask

  task automatic test_zero_size;
    int s0, d0, v0;
    s0 = n_starts; d0 = n_done; v0 = n_valid_cycles;
    exp_q.delete(); exp_z_q.delete();
    drive_cfg(0, 4, 32'h1234_5678, '0, 32'h0100_0000, '0, '0, 5);
    frame_start_i = 1'b1;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (frame_done_o !== 1'b1) begin
      errors++; $display("FAIL zero_done: got frame_done=%0b, required 1", frame_done_o);
    end
    @(negedge clk_i);
    checks++;
    if ({frame_done_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL zero_after: got done=%0b busy=%0b, required 0 0", frame_done_o, busy_o);
    end
    repeat (5) @(negedge clk_i);
    checks++;
    if (n_starts !== s0 || n_valid_cycles !== v0 || n_done - d0 !== 1) begin
      errors++; $display("FAIL zero_quiet: starts=%0d valid_cycles=%0d dones=%0d, required 0 0 1", n_starts - s0, n_valid_cycles - v0, n_done - d0);
    end
  endtask

  task automatic test_restart_ignored;
    int st, dn, vi, mx; bit tmo;
    run_frame(4, 3, 32'hFE80_0000, 32'h00C0_0000, 32'h0060_0000, 32'hFFC0_0000, 32'h0020_0000, 15, 100, 1'b0, 1'b1, st, dn, vi, mx, tmo);
    checks++;
    if (tmo !== 1'b0 || st !== 12 || dn !== 1 || obs_q.size() !== 12 || exp_q.size() !== 0) begin
      errors++; $display("FAIL restart_ignored: timeout=%0b starts=%0d dones=%0d pixels=%0d, required 0 12 1 12", tmo, st, dn, obs_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int st, dn, vi, mx, s0, d0; bit tmo, seen;
    build_expected(3, 2, 32'hFF00_0000, 32'h0080_0000, 32'h0080_0000, '0, '0, 20);
    drive_cfg(3, 2, 32'hFF00_0000, 32'h0080_0000, 32'h0080_0000, '0, '0, 20);
    frame_start_i = 1'b1; pix_ready_i = 1'b1;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (core_start_o) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL reset_mid_start: no core_start within 20 cycles, required one");
    end
    @(posedge clk_i); #1;
    d0 = n_done;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({core_start_o, core_zx_o, core_zy_o, core_cx_o, core_cy_o, core_max_iter_o, pix_valid_o, pix_iter_o,
         pix_x_o, pix_y_o, pix_eol_o, pix_last_o, busy_o, frame_done_o} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got busy=%0b valid=%0b zx=%h zy=%h, required all zero", busy_o, pix_valid_o, core_zx_o, core_zy_o);
    end
    s0 = n_starts;
    repeat (5) @(negedge clk_i);
    checks++;
    if (n_done !== d0 || n_starts !== s0) begin
      errors++; $display("FAIL reset_mid_idle: dones=%0d starts=%0d after reset, required 0 0", n_done - d0, n_starts - s0);
    end
    run_frame(3, 2, 32'hFF00_0000, 32'h0080_0000, 32'h0080_0000, '0, '0, 20, 70, 1'b0, 1'b0, st, dn, vi, mx, tmo);
    checks++;
    if (tmo !== 1'b0 || st !== 6 || dn !== 1 || obs_q.size() !== 6 || exp_q.size() !== 0) begin
      errors++; $display("FAIL reset_mid_rerun: timeout=%0b starts=%0d dones=%0d pixels=%0d, required 0 6 1 6", tmo, st, dn, obs_q.size());
    end
  endtask

  task automatic test_random_frames;
    int st, dn, vi, mx, w, h; bit tmo;
    logic [DW-1:0] cx, cy, step;
    for (int k = 0; k < 4; k++) begin
      w = int'($urandom_range(1, 5));
      h = int'($urandom_range(1, 4));
      cx = DW'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000;
      cy = DW'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000;
      step = DW'($urandom_range(32'h0010_0000, 32'h0080_0000));
      run_frame(w, h, 32'hFE80_0000, 32'h0100_0000, step, cx, cy, int'($urandom_range(5, 30)),
                50, 1'b0, 1'b0, st, dn, vi, mx, tmo);
      checks++;
      if (tmo !== 1'b0 || st !== w * h || dn !== 1 || obs_q.size() !== w * h || exp_q.size() !== 0 || vi !== 0 || mx > 2) begin
        errors++;
        $display("FAIL random_frame %0d (%0dx%0d): timeout=%0b starts=%0d dones=%0d pixels=%0d unstable=%0d outstanding=%0d",
                 k, w, h, tmo, st, dn, obs_q.size(), vi, mx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_2x1();
    test_3x2();
    test_backpressure();
    test_zero_size();
    test_restart_ignored();
    test_reset_mid();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
